cmd_issue_queue: RTL and testbench

- Upstream command source for the ALU top level; drives its 12-bit `command` bus and its `run` strobe.
- Buffers commands pushed by a host or testbench in a small FIFO.
- Issues one command at a time: a single-cycle `run` pulse, then `command` held stable for HOLD_CYCLES so the controller, the operand registers and the ALU settle before the next command.

---
 rtl/cmd_issue_queue.sv | 131 +++++++++++++
 tb/tb_cmd_issue_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_queue.sv
// Command FIFO feeding the ALU top level: pops one entry at a time, pulses run,
// then holds command stable for HOLD_CYCLES before the next issue may start.
module cmd_issue_queue #(
    parameter int unsigned CMD_W       = 12,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CMD_W-1:0]         cmd_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     enable,
    input  logic                     flush,
    output logic [CMD_W-1:0]         command,
    output logic                     run,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     drop_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [CMD_W-1:0]  command_q, command_d;
    logic              run_q, run_d;
    logic              drop_q, drop_d;
    logic [CMD_W-1:0]  mem_q [DEPTH];
    logic              push, pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign count     = count_q;
    assign command   = command_q;
    assign run       = run_q;
    assign busy      = (state_q != IDLE);
    assign drop_err  = drop_q;

    // Both decisions use registered status, so a push into an empty queue
    // cannot pop on the same edge and a full queue never passes through.
    assign push = cmd_valid && !full && !flush;
    assign pop  = (state_q == IDLE) && enable && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        command_d = command_q;
        run_d     = 1'b0;
        drop_d    = drop_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (cmd_valid && full) drop_d = 1'b1;
        end

        // flush only touches the queue; an issue in flight runs to completion.
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = ISSUE;
                    command_d = mem_q[rd_ptr_q];
                    run_d     = 1'b1;
                end
            end
            ISSUE: begin
                hold_d  = HOLD_LD;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            command_q <= '0;
            run_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            command_q <= command_d;
            run_q     <= run_d;
            drop_q    <= drop_d;
        end
    end

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Self-checking bench for cmd_issue_queue: directed table, scenario sequences
// and random traffic, all compared against a queue-based reference model.
module tb_cmd_issue_queue;

    localparam int CMD_W = 12;
    localparam int DEPTH = 8;
    localparam int HOLD  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CMD_W-1:0] cmd_in = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             enable = 1'b0;
    logic             flush = 1'b0;
    logic [CMD_W-1:0] command;
    logic             run;
    logic             busy;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             drop_err;

    cmd_issue_queue #(.CMD_W(CMD_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .enable(enable), .flush(flush),
        .command(command), .run(run), .busy(busy), .count(count),
        .empty(empty), .full(full), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: FIFO contents, last issued command, and the number of
    // cycles the current issue still occupies (1 run cycle + HOLD cycles).
    int         mq[$];
    logic [11:0] m_cmd;
    logic        m_run;
    int          m_left;
    logic        m_drop;

    int run_cyc[$];
    int run_val[$];

    typedef struct {
        logic        v;
        logic [11:0] d;
        logic        en;
        logic        fl;
        logic        e_run;
        logic [11:0] e_cmd;
        int          e_cnt;
        logic        e_busy;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cmd  = '0;
        m_run  = 1'b0;
        m_left = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_step();
        int  sz;
        bit  do_pop, do_push;
        sz      = mq.size();
        do_pop  = (m_left == 0) && enable && (sz > 0) && !flush;
        do_push = cmd_valid && (sz < DEPTH) && !flush;
        if (flush) m_drop = 1'b0;
        else if (cmd_valid && sz == DEPTH) m_drop = 1'b1;
        if (do_pop) begin
            m_cmd  = 12'(mq.pop_front());
            m_run  = 1'b1;
            m_left = HOLD + 1;
        end else begin
            m_run = 1'b0;
            if (m_left > 0) m_left--;
        end
        if (flush) mq.delete();
        if (do_push) mq.push_back(int'(cmd_in));
    endtask

    task automatic compare_all();
        check("run", 32'(run), 32'(m_run));
        check("command", 32'(command), 32'(m_cmd));
        check("count", 32'(count), 32'(mq.size()));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
        check("drop_err", 32'(drop_err), 32'(m_drop));
        if (run === 1'b1) begin
            run_cyc.push_back(cyc);
            run_val.push_back(int'(command));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    // Called at posedge+1; reset hits mid-cycle and is checked before any edge.
    task automatic async_reset();
        cmd_valid = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_run", 32'(run), 32'd0);
        check("rst_command", 32'(command), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        async_reset();

        // Directed table: 0x7FF into empty queue, then two pushes during its hold.
        tbl[0] = '{1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0, 12'h000, 1, 1'b0};
        tbl[1] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h7FF, 0, 1'b1};
        tbl[2] = '{1'b1, 12'h123, 1'b1, 1'b0, 1'b0, 12'h7FF, 1, 1'b1};
        tbl[3] = '{1'b1, 12'h456, 1'b1, 1'b0, 1'b0, 12'h7FF, 2, 1'b1};
        tbl[4] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h7FF, 2, 1'b1};
        tbl[5] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h7FF, 2, 1'b0};
        tbl[6] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h123, 1, 1'b1};
        tbl[7] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h123, 1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            cmd_valid = tbl[i].v;
            cmd_in    = tbl[i].d;
            enable    = tbl[i].en;
            flush     = tbl[i].fl;
            tick();
            check("tbl_run", 32'(run), 32'(tbl[i].e_run));
            check("tbl_command", 32'(command), 32'(tbl[i].e_cmd));
            check("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
            check("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
        end
        cmd_valid = 1'b0;
        async_reset();

        // Three commands back to back: run period HOLD+2.
        run_cyc.delete();
        run_val.delete();
        enable = 1'b1;
        cmd_valid = 1'b1;
        cmd_in = 12'h101; tick();
        cmd_in = 12'h202; tick();
        cmd_in = 12'h303; tick();
        cmd_valid = 1'b0;
        repeat (20) tick();
        check("seq1_runs", 32'(run_val.size()), 32'd3);
        if (run_val.size() == 3) begin
            check("seq1_v0", 32'(run_val[0]), 32'h101);
            check("seq1_v1", 32'(run_val[1]), 32'h202);
            check("seq1_v2", 32'(run_val[2]), 32'h303);
            check("seq1_gap0", 32'(run_cyc[1] - run_cyc[0]), 32'(HOLD + 2));
            check("seq1_gap1", 32'(run_cyc[2] - run_cyc[1]), 32'(HOLD + 2));
        end
        check("seq1_count", 32'(count), 32'd0);
        check("seq1_busy", 32'(busy), 32'd0);

        // Fill with enable low, overflow once, then drain.
        enable = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cmd_valid = 1'b1;
            cmd_in = 12'(i);
            tick();
            if (i == 8) begin
                check("fill_full", 32'(full), 32'd1);
                check("fill_ready", 32'(cmd_ready), 32'd0);
            end
        end
        cmd_valid = 1'b0;
        check("fill_drop", 32'(drop_err), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        run_cyc.delete();
        run_val.delete();
        enable = 1'b1;
        repeat (50) tick();
        check("drain_runs", 32'(run_val.size()), 32'd8);
        for (int i = 0; i < run_val.size() && i < 8; i++)
            check("drain_val", 32'(run_val[i]), 32'(i + 1));

        // Wrap-around: 20 commands with the queue kept partly filled.
        run_cyc.delete();
        run_val.delete();
        begin
            int pushed = 0;
            for (int c = 0; c < 400 && run_val.size() < 20; c++) begin
                cmd_valid = (pushed < 20) && (mq.size() < 5);
                cmd_in = 12'(12'h0A0 + pushed);
                tick();
                if (cmd_valid) pushed++;
            end
        end
        cmd_valid = 1'b0;
        check("wrap_runs", 32'(run_val.size()), 32'd20);
        for (int i = 0; i < run_val.size() && i < 20; i++)
            check("wrap_val", 32'(run_val[i]), 32'(12'h0A0 + i));

        // Flush during HOLD of 0x111 with 4 queued, plus a simultaneous push.
        repeat (8) tick();
        run_cyc.delete();
        run_val.delete();
        cmd_valid = 1'b1;
        cmd_in = 12'h111; tick();
        for (int i = 1; i <= 4; i++) begin
            cmd_in = 12'(12'h110 + 2 * i);
            tick();
        end
        check("flush_pre_busy", 32'(busy), 32'd1);
        check("flush_pre_count", 32'(count), 32'd4);
        cmd_in = 12'hEEE;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_drop", 32'(drop_err), 32'd0);
        check("flush_command", 32'(command), 32'h111);
        repeat (15) tick();
        check("flush_runs", 32'(run_val.size()), 32'd1);

        // Asynchronous reset during ISSUE.
        cmd_valid = 1'b1;
        cmd_in = 12'h5A5; tick();
        cmd_in = 12'h6B6; tick();
        cmd_valid = 1'b0;
        begin
            int waited = 0;
            while (run !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            check("issue_seen", 32'(run), 32'd1);
        end
        async_reset();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_in    = 12'($urandom);
            enable    = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
